heap_memory: RTL and testbench
==============================

HEAP_MEMORY -- requirements
Module: heap_memory

Interface
REQ-001 SHALL have parameter ARRAYS, default 4: number of allocatable arrays.
REQ-002 SHALL have parameter ELEMENTS, default 8: maximum elements per array.
REQ-003 SHALL have parameter WIDTH, default 12: element width in bits.
REQ-004 SHALL have port clock  input  1: single clock; all state changes on posedge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port start  input  1: request strobe, sampled only in IDLE.
REQ-007 SHALL have port action  input  8: operation code.
REQ-008 SHALL have port array  input  clog2(ARRAYS): target array id.
REQ-009 SHALL have port index  input  clog2(ELEMENTS+1): element index or new size.
REQ-010 SHALL have port inData  input  WIDTH: write/push data.
REQ-011 SHALL have port busy  output  1: high whenever FSM is not IDLE.
REQ-012 SHALL have port done  output  1: one-cycle completion pulse.
REQ-013 SHALL have port outData  output  WIDTH: result, zero-extended where narrower.
REQ-014 SHALL have port error  output  3: result status, valid with done.

Function
REQ-015 SHALL use action codes: 1 Reset, 2 Allocate, 3 Free, 4 Read, 5 Write, 6 Size, 7 Push, 8 Pop, 9 Resize; any other code -> error 6.
REQ-016 SHALL use error codes: 0 ok, 1 no free array, 2 array not allocated, 3 index out of range, 4 array full, 5 array empty, 6 bad action.
REQ-017 SHALL run FSM IDLE -> EXECUTE -> RESPOND -> IDLE; start in IDLE captures all inputs; done pulses in RESPOND, exactly 2 cycles after capture.
REQ-018 SHALL ignore start while busy; captured operands SHALL NOT change mid-operation.
REQ-019 Reset action SHALL mark all arrays free and all sizes 0; outData 0, error 0.
REQ-020 Allocate SHALL grant the lowest-numbered free array, mark it allocated with size 0, return id on outData; none free -> error 1.
REQ-021 Free SHALL mark array free and size 0; unallocated -> error 2.
REQ-022 Read SHALL return element index; index >= size -> error 3.
REQ-023 Write SHALL store at index when index < size; index == size < ELEMENTS SHALL append (size+1); index > size or index == ELEMENTS -> error 3.
REQ-024 Size SHALL return current size.
REQ-025 Push SHALL store at size and increment; size == ELEMENTS -> error 4.
REQ-026 Pop SHALL return element size-1 and decrement; size == 0 -> error 5.
REQ-027 Resize SHALL set size to index when index <= ELEMENTS, else error 3; element contents unchanged.
REQ-028 Operations 4-9 on an unallocated array SHALL give error 2 (checked before other errors).
REQ-029 Any error SHALL leave all state unchanged and drive outData 0.
REQ-030 outData and error SHALL hold their values until the next done.

Reset
REQ-031 reset SHALL force IDLE, busy 0, done 0, outData 0, error 0, all arrays free, all sizes 0 on the next posedge, aborting any operation in flight without a done pulse.
REQ-032 Element storage need not be cleared by reset; reads are guarded by size.

Structure
REQ-033 Action codes, error codes and FSM state type SHALL live in package heap_pkg.
REQ-034 Lowest-free-id search SHALL be sub-module heap_first_free (combinational priority encoder over the allocated bitmap, with a none-free flag).
REQ-035 Element storage SHALL be one ARRAYS*ELEMENTS x WIDTH memory addressed {array,index}.

Verification
REQ-036 reset; Allocate x4 -> outData 0,1,2,3, error 0; fifth Allocate -> error 1.
REQ-037 Free 1; Allocate -> outData 1; Free 1 twice -> second gives error 2.
REQ-038 Array 0: Push 5, Push 7, Size -> 2; Pop -> 7; Read 0 -> 5; Read 1 -> error 3.
REQ-039 Push 8 times to array 2 -> error 0 each; 9th -> error 4; Pop 8 times then Pop -> error 5.
REQ-040 Write array 3 index 0 value 12'hABC -> size 1; Write index 2 -> error 3; Resize 9 -> error 3; Resize 8 then Size -> 8; action 0x20 -> error 6.
REQ-041 start then reset asserted in EXECUTE -> no done, busy 0 next cycle, subsequent Size on array 0 -> error 2.

Source files
------------

// File: rtl/heap_pkg.sv
// Shared types for the heap memory block: operation codes, result codes and FSM states.
package heap_pkg;

  typedef enum logic [7:0] {
    ActReset    = 8'd1,
    ActAllocate = 8'd2,
    ActFree     = 8'd3,
    ActRead     = 8'd4,
    ActWrite    = 8'd5,
    ActSize     = 8'd6,
    ActPush     = 8'd7,
    ActPop      = 8'd8,
    ActResize   = 8'd9
  } action_e;

  typedef enum logic [2:0] {
    ErrOk        = 3'd0,
    ErrNoFree    = 3'd1,
    ErrNotAlloc  = 3'd2,
    ErrRange     = 3'd3,
    ErrFull      = 3'd4,
    ErrEmpty     = 3'd5,
    ErrBadAction = 3'd6
  } error_e;

  typedef enum logic [1:0] {
    StIdle,
    StExecute,
    StRespond
  } state_e;

endpackage

// File: rtl/heap_first_free.sv
// Priority encoder: lowest-numbered array whose allocated bit is clear.
module heap_first_free #(
  parameter int unsigned ARRAYS = 4
) (
  input  logic [ARRAYS-1:0]         allocated,
  output logic [$clog2(ARRAYS)-1:0] id,
  output logic                      none_free
);

  always_comb begin
    id        = '0;
    none_free = &allocated;
    // Scan downwards so the lowest free index wins.
    for (int i = ARRAYS - 1; i >= 0; i--) begin
      if (!allocated[i]) id = ($clog2(ARRAYS))'(i);
    end
  end

endmodule

// File: rtl/heap_memory.sv
// Small array heap: allocate/free fixed-capacity arrays and operate on their elements
// through a three-state IDLE -> EXECUTE -> RESPOND request handshake.
module heap_memory
  import heap_pkg::*;
#(
  parameter int unsigned ARRAYS   = 4,
  parameter int unsigned ELEMENTS = 8,
  parameter int unsigned WIDTH    = 12
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [7:0]                     action,
  input  logic [$clog2(ARRAYS)-1:0]      array,
  input  logic [$clog2(ELEMENTS+1)-1:0]  index,
  input  logic [WIDTH-1:0]               inData,
  output logic                           busy,
  output logic                           done,
  output logic [WIDTH-1:0]               outData,
  output logic [2:0]                     error
);

  localparam int unsigned AW    = $clog2(ARRAYS);
  localparam int unsigned IW    = $clog2(ELEMENTS + 1);
  localparam int unsigned Depth = ARRAYS * ELEMENTS;
  localparam int unsigned MW    = $clog2(Depth);
  localparam logic [IW-1:0] MaxSize = IW'(ELEMENTS);

  state_e             state_q;
  logic [7:0]         act_q;
  logic [AW-1:0]      arr_q;
  logic [IW-1:0]      idx_q;
  logic [WIDTH-1:0]   data_q;
  logic [ARRAYS-1:0]  alloc_q;
  logic [IW-1:0]      size_q [ARRAYS];
  logic [WIDTH-1:0]   mem [Depth];
  logic               done_q;
  logic [WIDTH-1:0]   out_q;
  error_e             err_q;

  logic [AW-1:0]      free_id;
  logic               none_free;

  heap_first_free #(
    .ARRAYS (ARRAYS)
  ) u_first_free (
    .allocated (alloc_q),
    .id        (free_id),
    .none_free (none_free)
  );

  logic [IW-1:0]    cur_size;
  logic             cur_alloc;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    wr_idx;
  logic [MW-1:0]    rd_addr;
  logic [MW-1:0]    wr_addr;
  error_e           err_d;
  logic [WIDTH-1:0] res_d;
  logic             mem_we;
  logic             size_upd;
  logic [IW-1:0]    size_new;
  logic             alloc_set;
  logic             alloc_clr;
  logic             clear_all;

  assign cur_size  = size_q[arr_q];
  assign cur_alloc = alloc_q[arr_q];
  assign rd_idx    = (act_q == ActPop) ? cur_size - IW'(1) : idx_q;
  assign wr_idx    = (act_q == ActPush) ? cur_size : idx_q;
  assign rd_addr   = MW'(arr_q) * MW'(ELEMENTS) + MW'(rd_idx);
  assign wr_addr   = MW'(arr_q) * MW'(ELEMENTS) + MW'(wr_idx);

  always_comb begin
    err_d     = ErrOk;
    res_d     = '0;
    mem_we    = 1'b0;
    size_upd  = 1'b0;
    size_new  = cur_size;
    alloc_set = 1'b0;
    alloc_clr = 1'b0;
    clear_all = 1'b0;
    case (act_q)
      ActReset: clear_all = 1'b1;
      ActAllocate: begin
        if (none_free) begin
          err_d = ErrNoFree;
        end else begin
          alloc_set = 1'b1;
          res_d     = WIDTH'(free_id);
        end
      end
      ActFree: begin
        if (!cur_alloc) err_d = ErrNotAlloc;
        else            alloc_clr = 1'b1;
      end
      ActRead, ActWrite, ActSize, ActPush, ActPop, ActResize: begin
        // Allocation is checked ahead of every operand-specific error.
        if (!cur_alloc) begin
          err_d = ErrNotAlloc;
        end else begin
          case (act_q)
            ActRead: begin
              if (idx_q >= cur_size) err_d = ErrRange;
              else                   res_d = mem[rd_addr];
            end
            ActWrite: begin
              if (idx_q < cur_size) begin
                mem_we = 1'b1;
              end else if (idx_q == cur_size && cur_size < MaxSize) begin
                mem_we   = 1'b1;
                size_upd = 1'b1;
                size_new = cur_size + IW'(1);
              end else begin
                err_d = ErrRange;
              end
            end
            ActSize: res_d = WIDTH'(cur_size);
            ActPush: begin
              if (cur_size == MaxSize) begin
                err_d = ErrFull;
              end else begin
                mem_we   = 1'b1;
                size_upd = 1'b1;
                size_new = cur_size + IW'(1);
              end
            end
            ActPop: begin
              if (cur_size == '0) begin
                err_d = ErrEmpty;
              end else begin
                res_d    = mem[rd_addr];
                size_upd = 1'b1;
                size_new = cur_size - IW'(1);
              end
            end
            default: begin // ActResize
              if (idx_q > MaxSize) begin
                err_d = ErrRange;
              end else begin
                size_upd = 1'b1;
                size_new = idx_q;
              end
            end
          endcase
        end
      end
      default: err_d = ErrBadAction;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      act_q   <= '0;
      arr_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      out_q   <= '0;
      err_q   <= ErrOk;
      alloc_q <= '0;
      for (int i = 0; i < ARRAYS; i++) size_q[i] <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            act_q   <= action;
            arr_q   <= array;
            idx_q   <= index;
            data_q  <= inData;
            state_q <= StExecute;
          end
        end
        StExecute: begin
          state_q <= StRespond;
          done_q  <= 1'b1;
          err_q   <= err_d;
          out_q   <= res_d;
          if (clear_all) begin
            alloc_q <= '0;
            for (int i = 0; i < ARRAYS; i++) size_q[i] <= '0;
          end
          if (alloc_set) begin
            alloc_q[free_id] <= 1'b1;
            size_q[free_id]  <= '0;
          end
          if (alloc_clr) begin
            alloc_q[arr_q] <= 1'b0;
            size_q[arr_q]  <= '0;
          end
          if (size_upd) size_q[arr_q] <= size_new;
        end
        StRespond: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage is never cleared; every read is guarded by the array size.
  always_ff @(posedge clock) begin
    if (!reset && state_q == StExecute && mem_we) mem[wr_addr] <= data_q;
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign outData = out_q;
  assign error   = err_q;

endmodule

// File: tb/tb_heap_memory.sv
// Directed bench for heap_memory with hand-computed expected results.
module tb_heap_memory;

  localparam logic [7:0] AReset = 8'd1, AAlloc = 8'd2, AFree = 8'd3, ARead = 8'd4,
                         AWrite = 8'd5, ASize = 8'd6, APush = 8'd7, APop = 8'd8,
                         AResize = 8'd9;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  action;
  logic [1:0]  array;
  logic [3:0]  index;
  logic [11:0] inData;
  logic        busy;
  logic        done;
  logic [11:0] outData;
  logic [2:0]  error;

  int n_cmp = 0;
  int n_bad = 0;

  heap_memory #(
    .ARRAYS   (4),
    .ELEMENTS (8),
    .WIDTH    (12)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .action  (action),
    .array   (array),
    .index   (index),
    .inData  (inData),
    .busy    (busy),
    .done    (done),
    .outData (outData),
    .error   (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble the inputs while busy, and check latency and result.
  task automatic op(input string tag, input logic [7:0] a, input logic [1:0] ar,
                    input logic [3:0] ix, input logic [11:0] d,
                    input logic [11:0] exp_out, input logic [2:0] exp_err);
    int lat;
    @(negedge clock);
    start = 1'b1; action = a; array = ar; index = ix; inData = d;
    @(negedge clock);
    start = 1'b0; action = 8'hFF; array = ~ar; index = 4'hF; inData = ~d;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 6) begin
      @(negedge clock);
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'd1);
    check({tag, ".out"}, 32'(outData), 32'(exp_out));
    check({tag, ".err"}, 32'(error), 32'(exp_err));
    @(negedge clock);
    check({tag, ".pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; action = '0; array = '0; index = '0; inData = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.out", 32'(outData), 32'd0);
    check("rst.err", 32'(error), 32'd0);

    for (int i = 0; i < 4; i++) op("alloc", AAlloc, 2'd0, 4'd0, 12'd0, 12'(i), 3'd0);
    op("alloc5", AAlloc, 2'd0, 4'd0, 12'd0, 12'd0, 3'd1);
    op("free1", AFree, 2'd1, 4'd0, 12'd0, 12'd0, 3'd0);
    op("realloc", AAlloc, 2'd0, 4'd0, 12'd0, 12'd1, 3'd0);
    op("free1a", AFree, 2'd1, 4'd0, 12'd0, 12'd0, 3'd0);
    op("free1b", AFree, 2'd1, 4'd0, 12'd0, 12'd0, 3'd2);
    op("rd_unalloc", ARead, 2'd1, 4'd0, 12'd0, 12'd0, 3'd2);

    op("push5", APush, 2'd0, 4'd0, 12'd5, 12'd0, 3'd0);
    op("push7", APush, 2'd0, 4'd0, 12'd7, 12'd0, 3'd0);
    op("size0", ASize, 2'd0, 4'd0, 12'd0, 12'd2, 3'd0);
    op("pop0", APop, 2'd0, 4'd0, 12'd0, 12'd7, 3'd0);
    op("read00", ARead, 2'd0, 4'd0, 12'd0, 12'd5, 3'd0);
    op("read01", ARead, 2'd0, 4'd1, 12'd0, 12'd0, 3'd3);

    for (int i = 0; i < 8; i++) op("push2", APush, 2'd2, 4'd0, 12'(16 + i), 12'd0, 3'd0);
    op("push2full", APush, 2'd2, 4'd0, 12'h3FF, 12'd0, 3'd4);
    for (int i = 7; i >= 0; i--) op("pop2", APop, 2'd2, 4'd0, 12'd0, 12'(16 + i), 3'd0);
    op("pop2empty", APop, 2'd2, 4'd0, 12'd0, 12'd0, 3'd5);

    op("wr30", AWrite, 2'd3, 4'd0, 12'hABC, 12'd0, 3'd0);
    op("size3a", ASize, 2'd3, 4'd0, 12'd0, 12'd1, 3'd0);
    op("wr32", AWrite, 2'd3, 4'd2, 12'h123, 12'd0, 3'd3);
    op("resize9", AResize, 2'd3, 4'd9, 12'd0, 12'd0, 3'd3);
    op("resize8", AResize, 2'd3, 4'd8, 12'd0, 12'd0, 3'd0);
    op("size3b", ASize, 2'd3, 4'd0, 12'd0, 12'd8, 3'd0);
    op("wr38", AWrite, 2'd3, 4'd8, 12'h111, 12'd0, 3'd3);
    op("read30", ARead, 2'd3, 4'd0, 12'd0, 12'hABC, 3'd0);
    repeat (3) @(negedge clock);
    check("hold.out", 32'(outData), 32'hABC);
    check("hold.err", 32'(error), 32'd0);
    op("badact", 8'h20, 2'd0, 4'd0, 12'd0, 12'd0, 3'd6);

    op("rstact", AReset, 2'd0, 4'd0, 12'd0, 12'd0, 3'd0);
    op("size_after_rst", ASize, 2'd0, 4'd0, 12'd0, 12'd0, 3'd2);
    op("alloc_after_rst", AAlloc, 2'd0, 4'd0, 12'd0, 12'd0, 3'd0);

    // Abort: reset asserted while the request is in EXECUTE.
    @(negedge clock);
    start = 1'b1; action = ASize; array = 2'd0; index = '0;
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("abort.done", 32'(done), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("abort.done2", 32'(done), 32'd0);
    op("size_after_abort", ASize, 2'd0, 4'd0, 12'd0, 12'd0, 3'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
